// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - unified memory request/ready handshake between control FSM and memory
interface mips_multicycle_ctrl_if;
   logic mem_req;
   logic mem_we;
   logic mem_ready;

   modport master (output mem_req, output mem_we, input mem_ready);
   modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM with memory wait watchdog
// Macro CTRL_ILLEGAL_TRAP_EN: illegal instructions enter a sticky TRAP state instead of NOP.
module mips_multicycle_ctrl #(
   parameter int WAIT_LIMIT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       alu_zero_n,
   mips_multicycle_ctrl_if.master memBus,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [3:0] alu_op,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       bus_err,
   output logic       trap,
   output logic [3:0] state_o
);
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC   = 4'd2,
      S_ALUWB  = 4'd3,
      S_MEMADR = 4'd4,
      S_MEMRD  = 4'd5,
      S_MEMWB  = 4'd6,
      S_MEMWR  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11,
      S_HALT   = 4'd12,
      S_TRAP   = 4'd13
   } state_t;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_SLT = 4'b0010;
   localparam logic [3:0] ALU_AND = 4'b0100;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_XOR = 4'b0110;
   localparam logic [3:0] ALU_NOR = 4'b0111;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [7:0] WAIT_CNT_LAST = 8'(WAIT_LIMIT - 1);

   state_t     state;
   state_t     nextState;
   state_t     illegalNext;
   logic [7:0] waitCnt;
   logic       memReqState;
   logic       waitExpired;
   logic       functOk;
   logic [3:0] functAluOp;
   logic       reqRaw;
   logic       weRaw;
   logic       irWriteRaw;
   logic       pcWriteRaw;
   logic       regWriteRaw;

`ifdef CTRL_ILLEGAL_TRAP_EN
   assign illegalNext = S_TRAP;
   assign trap        = (state == S_TRAP);
`else
   assign illegalNext = S_FETCH;
   assign trap        = 1'b0;
`endif

   assign memReqState = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
   assign waitExpired = memReqState && !memBus.mem_ready && (waitCnt == WAIT_CNT_LAST);

   always_comb begin
      functOk    = 1'b1;
      functAluOp = ALU_ADD;
      case (funct)
         6'b100000: functAluOp = ALU_ADD;
         6'b100010: functAluOp = ALU_SUB;
         6'b100100: functAluOp = ALU_AND;
         6'b100101: functAluOp = ALU_OR;
         6'b100110: functAluOp = ALU_XOR;
         6'b100111: functAluOp = ALU_NOR;
         6'b101010: functAluOp = ALU_SLT;
         default:   functOk    = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_FETCH;
         waitCnt <= 8'd0;
         bus_err <= 1'b0;
      end else begin
         state <= nextState;
         if (!memReqState || memBus.mem_ready) begin
            waitCnt <= 8'd0;
         end else begin
            waitCnt <= waitCnt + 8'd1;
         end
         if (waitExpired) begin
            bus_err <= 1'b1;
         end
      end
   end

   always_comb begin
      nextState   = state;
      reqRaw      = 1'b0;
      weRaw       = 1'b0;
      iord        = 1'b0;
      irWriteRaw  = 1'b0;
      pcWriteRaw  = 1'b0;
      pc_src      = 2'b00;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      alu_op      = ALU_ADD;
      regWriteRaw = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      case (state)
         S_FETCH: begin
            reqRaw    = 1'b1;
            alu_src_b = 2'b01;
            if (memBus.mem_ready) begin
               irWriteRaw = 1'b1;
               pcWriteRaw = 1'b1;
               nextState  = S_DECODE;
            end else if (waitExpired) begin
               nextState = S_HALT;
            end
         end
         S_DECODE: begin
            // Branch target is computed speculatively here and parked in ALUOut.
            alu_src_b = 2'b11;
            case (opcode)
               OP_RTYPE:     nextState = functOk ? S_EXEC : illegalNext;
               OP_LW, OP_SW: nextState = S_MEMADR;
               OP_BEQ:       nextState = S_BRANCH;
               OP_ADDI:      nextState = S_ADDIEX;
               OP_J:         nextState = S_JUMP;
               default:      nextState = illegalNext;
            endcase
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = functAluOp;
            nextState = S_ALUWB;
         end
         S_ALUWB: begin
            regWriteRaw = 1'b1;
            reg_dst     = 1'b1;
            nextState   = S_FETCH;
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nextState = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            reqRaw = 1'b1;
            iord   = 1'b1;
            if (memBus.mem_ready) begin
               nextState = S_MEMWB;
            end else if (waitExpired) begin
               nextState = S_HALT;
            end
         end
         S_MEMWB: begin
            regWriteRaw = 1'b1;
            mem_to_reg  = 1'b1;
            nextState   = S_FETCH;
         end
         S_MEMWR: begin
            reqRaw = 1'b1;
            weRaw  = 1'b1;
            iord   = 1'b1;
            if (memBus.mem_ready) begin
               nextState = S_FETCH;
            end else if (waitExpired) begin
               nextState = S_HALT;
            end
         end
         S_BRANCH: begin
            alu_src_a  = 1'b1;
            alu_op     = ALU_SUB;
            pc_src     = 2'b01;
            pcWriteRaw = ~alu_zero_n;
            nextState  = S_FETCH;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nextState = S_ADDIWB;
         end
         S_ADDIWB: begin
            regWriteRaw = 1'b1;
            nextState   = S_FETCH;
         end
         S_JUMP: begin
            pc_src     = 2'b10;
            pcWriteRaw = 1'b1;
            nextState  = S_FETCH;
         end
         S_HALT:  nextState = S_HALT;
         S_TRAP:  nextState = S_TRAP;
         default: nextState = S_FETCH;
      endcase
   end

   // Strobes are qualified by rst_n so a reset mid-access drops them without waiting for a clock.
   assign memBus.mem_req = reqRaw & rst_n;
   assign memBus.mem_we  = weRaw & rst_n;
   assign ir_write       = irWriteRaw & rst_n;
   assign pc_write       = pcWriteRaw & rst_n;
   assign reg_write      = regWriteRaw & rst_n;
   assign state_o        = state;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;
   localparam int FETCH_ENC = 0;
   localparam int MAX_CYC   = 40;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       aluZeroN;
   logic       iord, irWrite, pcWrite, aluSrcA, regWrite, regDst, memToReg, busErr, trap;
   logic [1:0] pcSrc, aluSrcB;
   logic [3:0] aluOp, stateO;

   int checks = 0;
   int errors = 0;

   mips_multicycle_ctrl_if bus ();

   mips_multicycle_ctrl #(.WAIT_LIMIT(15)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .funct      (funct),
      .alu_zero_n (aluZeroN),
      .memBus     (bus.master),
      .iord       (iord),
      .ir_write   (irWrite),
      .pc_write   (pcWrite),
      .pc_src     (pcSrc),
      .alu_src_a  (aluSrcA),
      .alu_src_b  (aluSrcB),
      .alu_op     (aluOp),
      .reg_write  (regWrite),
      .reg_dst    (regDst),
      .mem_to_reg (memToReg),
      .bus_err    (busErr),
      .trap       (trap),
      .state_o    (stateO)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic       zn;
      int         len;
      int         decB;
      int         alu3;
      int         srcA3;
      int         srcB3;
      int         regW;
      int         memWe;
      int         pcW;
      int         irW;
      int         regDstV;
      int         m2r;
      int         pcSrcLast;
      int         iordCyc;
   } vec_t;

   vec_t vecs[$];
   vec_t expQ[$];

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic zn,
                               input int len, input int alu3, input int srcA3, input int srcB3,
                               input int regW, input int memWe, input int pcW, input int rd,
                               input int m2r, input int pcSrcLast, input int iordCyc);
      vec_t v;
      v.op = op; v.fn = fn; v.zn = zn; v.len = len; v.decB = 3;
      v.alu3 = alu3; v.srcA3 = srcA3; v.srcB3 = srcB3;
      v.regW = regW; v.memWe = memWe; v.pcW = pcW; v.irW = 1;
      v.regDstV = rd; v.m2r = m2r; v.pcSrcLast = pcSrcLast; v.iordCyc = iordCyc;
      return v;
   endfunction

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Called inside a low clock phase with the DUT in FETCH; returns at a negedge back in FETCH.
   task automatic runInstr(input vec_t v, output vec_t g);
      int  c;
      bit  done;
      g = v;
      g.len = 0; g.decB = 0; g.alu3 = 0; g.srcA3 = 0; g.srcB3 = 0; g.regW = 0; g.memWe = 0;
      g.pcW = 0; g.irW = 0; g.regDstV = 0; g.m2r = 0; g.pcSrcLast = 0; g.iordCyc = 0;
      opcode        = v.op;
      funct         = v.fn;
      aluZeroN      = v.zn;
      bus.mem_ready = 1'b1;
      c    = 0;
      done = 1'b0;
      while (!done && c < MAX_CYC) begin
         #1;
         if (c == 1) g.decB = int'(aluSrcB);
         if (c == 2) begin
            g.alu3  = int'(aluOp);
            g.srcA3 = int'(aluSrcA);
            g.srcB3 = int'(aluSrcB);
         end
         if (regWrite) begin
            g.regW++;
            g.regDstV = int'(regDst);
            g.m2r     = int'(memToReg);
         end
         if (bus.mem_we) g.memWe++;
         if (irWrite) g.irW++;
         if (pcWrite) begin
            g.pcW++;
            g.pcSrcLast = int'(pcSrc);
         end
         if (bus.mem_req && iord) g.iordCyc++;
         c++;
         @(negedge clk);
         if (int'(stateO) == FETCH_ENC) done = 1'b1;
      end
      g.len = c;
   endtask

   initial begin
      vec_t got;
      vec_t e;
      int   c;
      int   held;
      int   waits;
      int   m2rSeen;
      bit   done;
      bit   sawWe;

      rst_n         = 1'b1;
      opcode        = 6'b0;
      funct         = 6'b0;
      aluZeroN      = 1'b0;
      bus.mem_ready = 1'b1;

      // op, fn, zn, len, alu3, srcA3, srcB3, regW, memWe, pcW, regDst, m2r, pcSrcLast, iordCyc
      vecs.push_back(mk(6'b000000, 6'b100000, 1'b0, 4, 4'b0000, 1, 0, 1, 0, 1, 1, 0, 0, 0));
      vecs.push_back(mk(6'b000000, 6'b100010, 1'b0, 4, 4'b0001, 1, 0, 1, 0, 1, 1, 0, 0, 0));
      vecs.push_back(mk(6'b000000, 6'b100100, 1'b0, 4, 4'b0100, 1, 0, 1, 0, 1, 1, 0, 0, 0));
      vecs.push_back(mk(6'b000000, 6'b100101, 1'b0, 4, 4'b0101, 1, 0, 1, 0, 1, 1, 0, 0, 0));
      vecs.push_back(mk(6'b000000, 6'b100110, 1'b0, 4, 4'b0110, 1, 0, 1, 0, 1, 1, 0, 0, 0));
      vecs.push_back(mk(6'b000000, 6'b100111, 1'b0, 4, 4'b0111, 1, 0, 1, 0, 1, 1, 0, 0, 0));
      vecs.push_back(mk(6'b000000, 6'b101010, 1'b0, 4, 4'b0010, 1, 0, 1, 0, 1, 1, 0, 0, 0));
      vecs.push_back(mk(6'b100011, 6'b000000, 1'b0, 5, 4'b0000, 1, 2, 1, 0, 1, 0, 1, 0, 1));
      vecs.push_back(mk(6'b101011, 6'b000000, 1'b0, 4, 4'b0000, 1, 2, 0, 1, 1, 0, 0, 0, 1));
      vecs.push_back(mk(6'b000100, 6'b000000, 1'b0, 3, 4'b0001, 1, 0, 0, 0, 2, 0, 0, 1, 0));
      vecs.push_back(mk(6'b000100, 6'b000000, 1'b1, 3, 4'b0001, 1, 0, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(6'b001000, 6'b000000, 1'b0, 4, 4'b0000, 1, 2, 1, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(6'b000010, 6'b000000, 1'b0, 3, 4'b0000, 0, 0, 0, 0, 2, 0, 0, 2, 0));
`ifndef CTRL_ILLEGAL_TRAP_EN
      vecs.push_back(mk(6'b111111, 6'b000000, 1'b0, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(6'b000000, 6'b000000, 1'b0, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
`endif

      // Reset state, including strobe gating while rst_n is low and mem_ready is high.
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mem_req", int'(bus.mem_req), 0);
      chk("rst_ir_write", int'(irWrite), 0);
      chk("rst_state", int'(stateO), FETCH_ENC);
      chk("rst_bus_err", int'(busErr), 0);
      chk("rst_trap", int'(trap), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("fetch_mem_req", int'(bus.mem_req), 1);
      chk("fetch_iord", int'(iord), 0);
      chk("fetch_src_b", int'(aluSrcB), 1);
      chk("fetch_alu_op", int'(aluOp), 0);

      // Table vectors through the scoreboard queue.
      foreach (vecs[i]) begin
         expQ.push_back(vecs[i]);
         runInstr(vecs[i], got);
         e = expQ.pop_front();
         chk($sformatf("v%0d_len", i), got.len, e.len);
         chk($sformatf("v%0d_dec_src_b", i), got.decB, e.decB);
         chk($sformatf("v%0d_alu_op3", i), got.alu3, e.alu3);
         chk($sformatf("v%0d_src_a3", i), got.srcA3, e.srcA3);
         chk($sformatf("v%0d_src_b3", i), got.srcB3, e.srcB3);
         chk($sformatf("v%0d_reg_write", i), got.regW, e.regW);
         chk($sformatf("v%0d_mem_we", i), got.memWe, e.memWe);
         chk($sformatf("v%0d_pc_write", i), got.pcW, e.pcW);
         chk($sformatf("v%0d_ir_write", i), got.irW, e.irW);
         chk($sformatf("v%0d_reg_dst", i), got.regDstV, e.regDstV);
         chk($sformatf("v%0d_mem_to_reg", i), got.m2r, e.m2r);
         chk($sformatf("v%0d_pc_src", i), got.pcSrcLast, e.pcSrcLast);
         chk($sformatf("v%0d_iord_cyc", i), got.iordCyc, e.iordCyc);
         chk($sformatf("v%0d_trap", i), int'(trap), 0);
      end

      // lw with three wait cycles in MEMRD.
      doReset();
      opcode  = 6'b100011;
      funct   = 6'b000000;
      c       = 0;
      held    = 0;
      waits   = 0;
      m2rSeen = 0;
      done    = 1'b0;
      while (!done && c < MAX_CYC) begin
         if (bus.mem_req && iord && waits < 3) begin
            bus.mem_ready = 1'b0;
            waits++;
         end else begin
            bus.mem_ready = 1'b1;
         end
         #1;
         if (bus.mem_req && iord && !bus.mem_ready) held++;
         if (regWrite) m2rSeen = int'(memToReg);
         c++;
         @(negedge clk);
         if (int'(stateO) == FETCH_ENC) done = 1'b1;
      end
      chk("lw_wait_len", c, 8);
      chk("lw_wait_held", held, 3);
      chk("lw_wait_m2r", m2rSeen, 1);
      chk("lw_wait_bus_err", int'(busErr), 0);

      // Unanswered fetch trips the watchdog after WAIT_LIMIT cycles.
      doReset();
      bus.mem_ready = 1'b0;
      #1;
      c = 0;
      while (bus.mem_req && c < MAX_CYC) begin
         c++;
         @(negedge clk);
         #1;
      end
      chk("buserr_cycles", c, 15);
      chk("buserr_set", int'(busErr), 1);
      chk("halt_not_fetch", int'(int'(stateO) == FETCH_ENC), 0);
      bus.mem_ready = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      chk("halt_sticky_err", int'(busErr), 1);
      chk("halt_mem_req", int'(bus.mem_req), 0);
      chk("halt_ir_write", int'(irWrite), 0);
      doReset();
      #1;
      chk("halt_exit_err", int'(busErr), 0);
      chk("halt_exit_state", int'(stateO), FETCH_ENC);

`ifdef CTRL_ILLEGAL_TRAP_EN
      // Illegal opcode parks in TRAP until reset.
      opcode        = 6'b111111;
      bus.mem_ready = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      chk("trap_set", int'(trap), 1);
      chk("trap_mem_req", int'(bus.mem_req), 0);
      chk("trap_reg_write", int'(regWrite), 0);
      doReset();
      #1;
      chk("trap_cleared", int'(trap), 0);
`endif

      // Reset asserted while a store is waiting for memory.
      doReset();
      opcode        = 6'b101011;
      bus.mem_ready = 1'b1;
      c     = 0;
      sawWe = 1'b0;
      while (!sawWe && c < MAX_CYC) begin
         #1;
         if (bus.mem_req && bus.mem_we) begin
            sawWe = 1'b1;
         end else begin
            c++;
            @(negedge clk);
            bus.mem_ready = (int'(stateO) == FETCH_ENC);
         end
      end
      chk("sw_reached_memwr", int'(sawWe), 1);
      rst_n = 1'b0;
      #1;
      chk("sw_rst_mem_req", int'(bus.mem_req), 0);
      chk("sw_rst_mem_we", int'(bus.mem_we), 0);
      chk("sw_rst_state", int'(stateO), FETCH_ENC);
      @(negedge clk);
      rst_n = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
